pkt_frame_ctrl: RTL and testbench
=================================

PKT_FRAME_CTRL -- requirements
Module: pkt_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'h1ACFFC1D, frame sync marker preceding each packet.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, largest legal payload-word count N.
REQ-003 SHALL have parameter HDR_TIMEOUT, default 3, cycles allowed in WAIT_HDR for hdr_valid.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_data  input  32  upstream telemetry word.
REQ-008 in_ready  output  1  word accepted when in_valid & in_ready.
REQ-009 abort  input  1  terminate the current packet immediately.
REQ-010 par_valid  output  1  word strobe to the header parser (its valid_in).
REQ-011 par_data  output  32  word to the header parser (its data_in).
REQ-012 par_reset  output  1  one-cycle clear of the header parser between packets.
REQ-013 hdr_in  input  48  parsed header from the parser.
REQ-014 hdr_valid  input  1  hdr_in valid strobe from the parser.
REQ-015 pkt_len  output  16  N latched from hdr_in[15:0].
REQ-016 pkt_start  output  1  one-cycle pulse on sync detection.
REQ-017 pkt_done  output  1  one-cycle pulse on normal packet completion.
REQ-018 pkt_err  output  1  one-cycle pulse on length, timeout or abort error.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 States: IDLE, HDR0, HDR1, WAIT_HDR, PAYLOAD, FLUSH.
REQ-021 in_ready = 1 in IDLE, HDR0, HDR1 and PAYLOAD; 0 in WAIT_HDR and FLUSH; forced 0 in any cycle where abort=1.
REQ-022 IDLE: accepted words are discarded (not forwarded); an accepted word equal to SYNC_WORD moves to HDR0 and pulses pkt_start next cycle.
REQ-023 HDR0: first accepted word is forwarded; go to HDR1.
REQ-024 HDR1: second accepted word is forwarded; go to WAIT_HDR with timeout counter cleared.
REQ-025 Forwarding is registered: par_valid/par_data update one cycle after acceptance; par_valid = 0 in every cycle with no forwarded acceptance.
REQ-026 WAIT_HDR: on hdr_valid, latch pkt_len = hdr_in[15:0]; if N = 0 go to FLUSH (done); if N > MAX_WORDS go to FLUSH (error); else load remaining-word counter with N and go to PAYLOAD.
REQ-027 WAIT_HDR: if hdr_valid is absent for HDR_TIMEOUT consecutive cycles, go to FLUSH (error).
REQ-028 PAYLOAD: each accepted word is forwarded and decrements the counter; the word that takes the counter from 1 to 0 moves to FLUSH (done).
REQ-029 FLUSH lasts exactly one cycle: par_reset = 1, pulse pkt_done or pkt_err per the entry cause, then go to IDLE.
REQ-030 abort = 1 in HDR0, HDR1, WAIT_HDR or PAYLOAD: no word is accepted that cycle; go to FLUSH (error). abort is ignored in IDLE and FLUSH.
REQ-031 abort coincident with the final payload word: abort wins; the word is not accepted; pkt_err asserts and pkt_done does not.
REQ-032 pkt_done and pkt_err are never both high; each is at most one cycle wide per packet.
REQ-033 hdr_valid outside WAIT_HDR is ignored.
REQ-034 A sync-valued word arriving in HDR0 through PAYLOAD is treated as data, not as resync.
REQ-035 Counters are 16-bit; no wrap is possible because N <= MAX_WORDS.

Reset
REQ-036 reset = 1 forces state IDLE and clears counters; at the next edge in_ready=1, par_valid=0, par_data=0, par_reset=1 (parser cleared with the controller), pkt_len=0, pkt_start=pkt_done=pkt_err=0, busy=0.
REQ-037 Mid-packet reset discards the packet with no pkt_done/pkt_err pulse; reset has priority over abort and all inputs.

Verification
REQ-038 Normal: SYNC, H0=32'hAAAA0000, H1, hdr_in[15:0]=3, 3 payload words -> 5 par_valid strobes, pkt_len=3, one pkt_done, one par_reset, busy returns 0.
REQ-039 Zero-length: hdr_in[15:0]=0 -> 2 forwarded words, pkt_done in FLUSH, no payload accepted.
REQ-040 Oversize: hdr_in[15:0]=1025 -> pkt_err, par_reset, IDLE; following words discarded until next SYNC.
REQ-041 Timeout: hdr_valid held 0 after H1 -> in_ready=0 for 3 cycles, then pkt_err and par_reset.
REQ-042 Abort with last payload word (N=2) -> word not accepted, pkt_err=1, pkt_done=0.
REQ-043 Reset asserted mid-PAYLOAD -> IDLE next cycle, no pulses; the next SYNC starts a clean packet.

Source files
------------

// File: rtl/pkt_frame_ctrl.sv
// Frames sync-delimited telemetry packets: two header words go to the parser, and the
// payload length comes back from it. Forwarding is one cycle behind acceptance; in_ready drops in WAIT_HDR/FLUSH and on abort.
module pkt_frame_ctrl #(
    parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
    parameter int          MAX_WORDS   = 1024,
    parameter int          HDR_TIMEOUT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        abort,
    output logic        par_valid,
    output logic [31:0] par_data,
    output logic        par_reset,
    input  logic [47:0] hdr_in,
    input  logic        hdr_valid,
    output logic [15:0] pkt_len,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic        busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR0     = 3'd1;
    localparam logic [2:0] S_HDR1     = 3'd2;
    localparam logic [2:0] S_WAIT_HDR = 3'd3;
    localparam logic [2:0] S_PAYLOAD  = 3'd4;
    localparam logic [2:0] S_FLUSH    = 3'd5;

    localparam logic [15:0] TMO_LAST = 16'(HDR_TIMEOUT - 1);
    localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] rem_cnt;
    logic [15:0] tmo_cnt;
    logic        accept;
    logic        fwd;
    logic        flush_err;
    logic        hdr_take;
    logic [15:0] hdr_n;
    logic        unused_hdr;

    assign unused_hdr = ^hdr_in[47:16];
    assign hdr_n      = hdr_in[15:0];

    assign in_ready = !abort && (state == S_IDLE || state == S_HDR0 ||
                                 state == S_HDR1 || state == S_PAYLOAD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign hdr_take = (state == S_WAIT_HDR) && hdr_valid && !abort;

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        flush_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && in_data == SYNC_WORD) state_nxt = S_HDR0;
            end
            S_HDR0, S_HDR1: begin
                if (abort) begin
                    state_nxt = S_FLUSH;
                    flush_err = 1'b1;
                end else if (accept) begin
                    fwd       = 1'b1;
                    state_nxt = (state == S_HDR0) ? S_HDR1 : S_WAIT_HDR;
                end
            end
            S_WAIT_HDR: begin
                if (abort) begin
                    state_nxt = S_FLUSH;
                    flush_err = 1'b1;
                end else if (hdr_valid) begin
                    if (hdr_n == 16'd0) begin
                        state_nxt = S_FLUSH;
                    end else if ({1'b0, hdr_n} > MAX_N) begin
                        state_nxt = S_FLUSH;
                        flush_err = 1'b1;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_FLUSH;
                    flush_err = 1'b1;
                end
            end
            S_PAYLOAD: begin
                // abort drops in_ready, so it wins over a final word in the same cycle
                if (abort) begin
                    state_nxt = S_FLUSH;
                    flush_err = 1'b1;
                end else if (accept) begin
                    fwd = 1'b1;
                    if (rem_cnt == 16'd1) state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rem_cnt   <= 16'd0;
            tmo_cnt   <= 16'd0;
            par_valid <= 1'b0;
            par_data  <= 32'd0;
            par_reset <= 1'b1;
            pkt_len   <= 16'd0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            par_valid <= fwd;
            if (fwd) par_data <= in_data;
            // pulses are registered on FLUSH entry so they line up with the FLUSH cycle
            par_reset <= (state_nxt == S_FLUSH);
            pkt_done  <= (state_nxt == S_FLUSH) && !flush_err;
            pkt_err   <= (state_nxt == S_FLUSH) && flush_err;
            pkt_start <= (state == S_IDLE) && accept && (in_data == SYNC_WORD);
            tmo_cnt   <= (state == S_WAIT_HDR) ? tmo_cnt + 16'd1 : 16'd0;
            if (hdr_take) begin
                pkt_len <= hdr_n;
                rem_cnt <= hdr_n;
            end else if (state == S_PAYLOAD && accept) begin
                rem_cnt <= rem_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_frame_ctrl.sv
// Randomized packet-level bench for pkt_frame_ctrl; expected outcomes come from packet rules.
module tb_pkt_frame_ctrl;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic        par_valid;
    logic [31:0] par_data;
    logic        par_reset;
    logic [47:0] hdr_in = 48'd0;
    logic        hdr_valid = 1'b0;
    logic [15:0] pkt_len;
    logic        pkt_start;
    logic        pkt_done;
    logic        pkt_err;
    logic        busy;

    pkt_frame_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .abort(abort), .par_valid(par_valid),
        .par_data(par_data), .par_reset(par_reset), .hdr_in(hdr_in),
        .hdr_valid(hdr_valid), .pkt_len(pkt_len), .pkt_start(pkt_start),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;
    int cnt_start = 0, cnt_done = 0, cnt_err = 0, cnt_prst = 0, cnt_both = 0;
    logic [31:0] got_q[$];
    logic [15:0] exp_len = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (par_valid) got_q.push_back(par_data);
        if (pkt_start) cnt_start++;
        if (pkt_done) cnt_done++;
        if (pkt_err) cnt_err++;
        if (par_reset) cnt_prst++;
        if (pkt_done && pkt_err) cnt_both++;
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = ($urandom % 4 == 0) ? SYNC : $urandom;
        return w;
    endfunction

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom;
        #1 check("abort_rdy", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic deliver_hdr(input int n);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        hdr_valid = 1'b1;
        hdr_in    = {16'($urandom), 16'($urandom), 16'(n)};
        @(posedge clk);
        #1 hdr_valid = 1'b0;
        exp_len = 16'(n);
    endtask

    // mode: 0 header delivered, 1 header timeout, 2 abort before H0,
    //       3 abort while waiting for header, 4 abort after k payload words
    task automatic run_packet(input int n, input int mode, input int k);
        logic [31:0] exp_q[$];
        logic [31:0] w, g;
        int s0, d0, e0, p0;
        bit exp_err;
        s0 = cnt_start; d0 = cnt_done; e0 = cnt_err; p0 = cnt_prst;
        got_q.delete();
        repeat ($urandom_range(0, 2)) begin
            g = $urandom;
            if (g == SYNC) g = g ^ 32'd1;
            send_word(g);
        end
        if ($urandom % 3 == 0) begin
            @(negedge clk);
            abort = 1'b1;
            #1 check("idle_abort_rdy", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            check("idle_abort_busy", {31'd0, busy}, 32'd0);
        end
        send_word(SYNC);
        if (mode == 2) begin
            pulse_abort();
        end else begin
            w = 32'hAAAA0000 | 32'($urandom_range(0, 255));
            send_word(w); exp_q.push_back(w);
            w = rand_word();
            send_word(w); exp_q.push_back(w);
            if (mode == 1) begin
                repeat (3) begin
                    @(negedge clk);
                    check("tmo_rdy", {31'd0, in_ready}, 32'd0);
                end
                @(negedge clk);
                check("tmo_err", {31'd0, pkt_err}, 32'd1);
                check("tmo_prst", {31'd0, par_reset}, 32'd1);
            end else if (mode == 3) begin
                pulse_abort();
            end else begin
                deliver_hdr(n);
                if (mode == 0 && n >= 1 && n <= MAXW) begin
                    for (int i = 0; i < n; i++) begin
                        w = rand_word();
                        send_word(w); exp_q.push_back(w);
                    end
                end else if (mode == 4) begin
                    for (int i = 0; i < k; i++) begin
                        w = rand_word();
                        send_word(w); exp_q.push_back(w);
                    end
                    pulse_abort();
                end
            end
        end
        exp_err = (mode != 0) || (n > MAXW);
        repeat (4) @(negedge clk);
        check("start_cnt", 32'(cnt_start - s0), 32'd1);
        check("done_cnt", 32'(cnt_done - d0), exp_err ? 32'd0 : 32'd1);
        check("err_cnt", 32'(cnt_err - e0), exp_err ? 32'd1 : 32'd0);
        check("prst_cnt", 32'(cnt_prst - p0), 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("pkt_len", {16'd0, pkt_len}, {16'd0, exp_len});
        check("fwd_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("fwd_data", got_q[i], exp_q[i]);
    endtask

    task automatic reset_mid_payload();
        int d0, e0;
        send_word(SYNC);
        send_word(32'hAAAA0000);
        send_word(32'h12345678);
        deliver_hdr(4);
        send_word(32'h0BADF00D);
        send_word(32'hCAFEBABE);
        d0 = cnt_done; e0 = cnt_err;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        check("rst_pvld", {31'd0, par_valid}, 32'd0);
        check("rst_pdat", par_data, 32'd0);
        check("rst_prst", {31'd0, par_reset}, 32'd1);
        check("rst_len", {16'd0, pkt_len}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_len = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_no_done", 32'(cnt_done - d0), 32'd0);
        check("rst_no_err", 32'(cnt_err - e0), 32'd0);
    endtask

    initial begin
        int n, mode, k, r;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("init_rdy", {31'd0, in_ready}, 32'd1);
        check("init_pvld", {31'd0, par_valid}, 32'd0);
        check("init_pdat", par_data, 32'd0);
        check("init_prst", {31'd0, par_reset}, 32'd1);
        check("init_len", {16'd0, pkt_len}, 32'd0);
        check("init_pulses", {29'd0, pkt_start, pkt_done, pkt_err}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_packet(3, 0, 0);
        run_packet(0, 0, 0);
        run_packet(MAXW + 1, 0, 0);
        run_packet(3, 1, 0);
        run_packet(2, 4, 1);
        reset_mid_payload();
        run_packet(2, 0, 0);
        run_packet(MAXW, 0, 0);

        for (int p = 0; p < 40; p++) begin
            mode = $urandom % 5;
            r = $urandom % 8;
            if (r == 0) n = 0;
            else if (r == 1) n = MAXW + 1;
            else if (r == 2) n = $urandom_range(MAXW + 2, 65535);
            else n = $urandom_range(1, 6);
            if (mode == 4 && (n == 0 || n > MAXW)) n = $urandom_range(1, 6);
            k = (n > 0) ? $urandom_range(0, n - 1) : 0;
            run_packet(n, mode, k);
        end

        check("done_err_overlap", 32'(cnt_both), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
